spike_scheduler: RTL and testbench
==================================

// Module: spike_scheduler
// PURPOSE
//  Per-core axon spike scheduler: the responder side of the token controller's scheduler_set/scheduler_clr interface.
//  Stores incoming router spikes in a circular NUM_TICKS x NUM_AXONS bit array, keyed by delivery tick.
//  Presents the current tick's axon spike vector to the token controller.
//  Sits between the router's local output port and the token controller's axon_spikes input.
// PARAMETERS
//  NUM_AXONS  256  axons per core; width of one tick row
//  NUM_TICKS  16   depth of the delivery window in ticks; must be a power of two and >= 2
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    synchronous, active-high reset
//  wr_en        in   1                    spike packet valid this cycle
//  wr_delay     in   $clog2(NUM_TICKS)    delivery offset d in ticks (0 = next tick)
//  wr_axon      in   $clog2(NUM_AXONS)    target axon index
//  sched_set    in   1                    advance to the next tick (from the token controller)
//  sched_clr    in   1                    clear the current tick row (from the token controller)
//  axon_spikes  out  NUM_AXONS            spike vector for the current tick
//  rd_ptr       out  $clog2(NUM_TICKS)    current tick row index (debug/verification)
//  error        out  1                    sticky; set on a dropped packet or on simultaneous set+clr
// BEHAVIOUR
//  - Reset (synchronous, priority over all inputs):
//    - All rows are cleared to 0.
//    - rd_ptr = 0, error = 0, axon_spikes = 0.
//  - Storage: mem[NUM_TICKS][NUM_AXONS] is a flip-flop array.
//    - axon_spikes = mem[rd_ptr], driven combinationally from registers.
//    - So axon_spikes reflects rd_ptr and clears the cycle after the edge that updates them (0-cycle read latency).
//  - Write:
//    - On a posedge with wr_en=1, the target row is row = (rd_ptr + 1 + wr_delay) mod NUM_TICKS.
//    - rd_ptr is the pre-edge value, even if sched_set is asserted in the same cycle.
//    - The write sets mem[row][wr_axon] = 1 (OR semantics); duplicate spikes are idempotent.
//  - Aliasing: wr_delay == NUM_TICKS-1 would target the current row.
//    - Such a packet is dropped, the array is left unchanged, and error is set.
//  - sched_set:
//    - rd_ptr <= (rd_ptr + 1) mod NUM_TICKS; wraps from NUM_TICKS-1 to 0.
//    - The row contents are not modified.
//  - sched_clr:
//    - mem[rd_ptr] <= 0, using the pre-edge rd_ptr.
//    - Writes can never target rd_ptr (see Aliasing), so there is no clr/write collision.
//  - sched_set and sched_clr together:
//    - Clear the old row and advance the pointer in the same edge.
//    - error is set; the token controller never issues both in one cycle.
//  - A write and sched_set in the same edge: the write lands using the old rd_ptr, then rd_ptr advances.
//  - Effective delivery: a packet written during tick T (rd_ptr=T) with delay d appears on axon_spikes after set number d+1.
//  - error is sticky and is cleared only by rst.
//  - There is no back-pressure: wr_en is accepted every cycle.
//  - Reset asserted mid-tick discards all pending spikes.
// TESTING
//  1. Reset, then write axon 5 with d=0, then pulse set -> rd_ptr=1, axon_spikes[5]=1, all other bits 0.
//  2. With rd_ptr=0, write axon 9 with d=2, then pulse set 3x -> axon_spikes[9]=0 after sets 1 and 2, =1 after set 3 (rd_ptr=3).
//  3. Pulse set 16x with no writes -> rd_ptr wraps 15->0; a row written at rd_ptr=14 with d=1 lands in row 0.
//  4. Write d=15 (NUM_TICKS-1) -> array unchanged, error=1 and stays 1 until rst.
//  5. At rd_ptr=1 with axon_spikes[5]=1, pulse clr -> next cycle axon_spikes==0 and rd_ptr still 1.
//  6. Same cycle: wr_en (axon 3, d=0) + sched_set at rd_ptr=4 -> rd_ptr=5 and mem[5][3]=1 (old-pointer write); then rst mid-tick -> all 0.

Source files
------------

// File: rtl/spike_scheduler.sv
// Per-core axon spike scheduler: a circular NUM_TICKS x NUM_AXONS flip-flop array of
// pending spikes keyed by delivery tick, with the current tick row presented combinationally.
module spike_scheduler #(
    parameter int NUM_AXONS = 256,
    parameter int NUM_TICKS = 16,
    localparam int TW = $clog2(NUM_TICKS),
    localparam int AW = $clog2(NUM_AXONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [TW-1:0]        wr_delay,
    input  logic [AW-1:0]        wr_axon,
    input  logic                 sched_set,
    input  logic                 sched_clr,
    output logic [NUM_AXONS-1:0] axon_spikes,
    output logic [TW-1:0]        rd_ptr,
    output logic                 error
);

    // Handshake: wr_en is a valid-only strobe with an implicit ready that is always 1.
    // A packet is consumed on every posedge where wr_en=1; there is no back-pressure.

    logic [NUM_AXONS-1:0] mem [NUM_TICKS];

    logic [TW-1:0]        wr_row;
    logic                 wr_alias;
    logic                 wr_accept;
    logic                 wr_drop;
    logic                 set_clr_both;
    logic [NUM_AXONS-1:0] wr_mask;

    // Row index wraps for free because NUM_TICKS is a power of two.
    assign wr_row       = rd_ptr + TW'(1) + wr_delay;
    assign wr_alias     = (wr_delay == TW'(NUM_TICKS - 1));
    assign wr_accept    = wr_en && !wr_alias;
    assign wr_drop      = wr_en && wr_alias;
    assign set_clr_both = sched_set && sched_clr;
    assign wr_mask      = {{(NUM_AXONS-1){1'b0}}, 1'b1} << wr_axon;

    assign axon_spikes  = mem[rd_ptr];

    // Accepted writes never address rd_ptr, so the clear and write branches cannot collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_TICKS; r++) begin
                mem[r] <= '0;
            end
            rd_ptr <= '0;
            error  <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_TICKS; r++) begin
                if (sched_clr && (rd_ptr == TW'(r))) begin
                    mem[r] <= '0;
                end else if (wr_accept && (wr_row == TW'(r))) begin
                    mem[r] <= mem[r] | wr_mask;
                end
            end
            if (sched_set) begin
                rd_ptr <= rd_ptr + TW'(1);
            end
            if (wr_drop || set_clr_both) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_scheduler.sv
// Directed bench for spike_scheduler: one task per scenario, each with inline expected-value checks.
module tb_spike_scheduler;

    localparam int NA = 256;
    localparam int NT = 16;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [3:0]    wr_delay;
    logic [7:0]    wr_axon;
    logic          sched_set;
    logic          sched_clr;
    logic [NA-1:0] axon_spikes;
    logic [3:0]    rd_ptr;
    logic          error;

    int checks = 0;
    int errors = 0;

    spike_scheduler #(.NUM_AXONS(NA), .NUM_TICKS(NT)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_delay    (wr_delay),
        .wr_axon     (wr_axon),
        .sched_set   (sched_set),
        .sched_clr   (sched_clr),
        .axon_spikes (axon_spikes),
        .rd_ptr      (rd_ptr),
        .error       (error)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Inputs change #1 after a posedge; outputs are sampled #1 after the next posedge.
    task automatic cycle(input logic w, input logic [3:0] d, input logic [7:0] a,
                         input logic s, input logic c, input logic r);
        wr_en     = w;
        wr_delay  = d;
        wr_axon   = a;
        sched_set = s;
        sched_clr = c;
        rst       = r;
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        wr_delay  = '0;
        wr_axon   = '0;
        sched_set = 1'b0;
        sched_clr = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic do_reset();
        cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_write(input logic [3:0] d, input logic [7:0] a);
        cycle(1'b1, d, a, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_set();
        cycle(1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        cycle(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [NA-1:0] exp_v;
        exp_v = '0;
        do_reset();
        checks++;
        if (rd_ptr !== 4'd0) begin
            errors++;
            $display("FAIL reset_rd_ptr: got %0d expected 0", rd_ptr);
        end
        checks++;
        if (axon_spikes !== exp_v) begin
            errors++;
            $display("FAIL reset_spikes: got %h expected %h", axon_spikes, exp_v);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL reset_error: got %b expected 0", error);
        end
    endtask

    task automatic test_single();
        logic [NA-1:0] exp_v;
        do_reset();
        do_write(4'd0, 8'd5);
        exp_v = '0;
        checks++;
        if (axon_spikes !== exp_v) begin
            errors++;
            $display("FAIL single_row0_empty: got %h expected %h", axon_spikes, exp_v);
        end
        do_set();
        exp_v[5] = 1'b1;
        checks++;
        if (rd_ptr !== 4'd1) begin
            errors++;
            $display("FAIL single_rd_ptr: got %0d expected 1", rd_ptr);
        end
        checks++;
        if (axon_spikes !== exp_v) begin
            errors++;
            $display("FAIL single_spikes: got %h expected %h", axon_spikes, exp_v);
        end
    endtask

    task automatic test_delay();
        logic [NA-1:0] exp_v;
        do_reset();
        do_write(4'd2, 8'd9);
        for (int i = 1; i <= 3; i++) begin
            do_set();
            exp_v = '0;
            if (i == 3) exp_v[9] = 1'b1;
            checks++;
            if (rd_ptr !== 4'(i)) begin
                errors++;
                $display("FAIL delay_rd_ptr set%0d: got %0d expected %0d", i, rd_ptr, i);
            end
            checks++;
            if (axon_spikes !== exp_v) begin
                errors++;
                $display("FAIL delay_spikes set%0d: got %h expected %h", i, axon_spikes, exp_v);
            end
        end
    endtask

    task automatic test_wrap();
        logic [NA-1:0] exp_v;
        do_reset();
        for (int i = 0; i < 14; i++) do_set();
        checks++;
        if (rd_ptr !== 4'd14) begin
            errors++;
            $display("FAIL wrap_rd_ptr14: got %0d expected 14", rd_ptr);
        end
        do_write(4'd1, 8'd7);   // row (14+1+1) mod 16 = 0
        do_set();
        exp_v = '0;
        checks++;
        if (rd_ptr !== 4'd15 || axon_spikes !== exp_v) begin
            errors++;
            $display("FAIL wrap_row15: got ptr=%0d spikes=%h expected ptr=15 spikes=%h",
                     rd_ptr, axon_spikes, exp_v);
        end
        do_set();
        exp_v[7] = 1'b1;
        checks++;
        if (rd_ptr !== 4'd0) begin
            errors++;
            $display("FAIL wrap_rd_ptr0: got %0d expected 0", rd_ptr);
        end
        checks++;
        if (axon_spikes !== exp_v) begin
            errors++;
            $display("FAIL wrap_row0_spikes: got %h expected %h", axon_spikes, exp_v);
        end
    endtask

    task automatic test_alias();
        logic [NA-1:0] exp_v;
        exp_v = '0;
        do_reset();
        do_write(4'd15, 8'd2);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL alias_error_set: got %b expected 1", error);
        end
        for (int i = 0; i < NT; i++) begin
            checks++;
            if (axon_spikes !== exp_v || error !== 1'b1) begin
                errors++;
                $display("FAIL alias_row%0d: got spikes=%h err=%b expected spikes=%h err=1",
                         rd_ptr, axon_spikes, error, exp_v);
            end
            do_set();
        end
        checks++;
        if (rd_ptr !== 4'd0) begin
            errors++;
            $display("FAIL alias_rd_ptr: got %0d expected 0", rd_ptr);
        end
        do_reset();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL alias_error_rst: got %b expected 0", error);
        end
    endtask

    task automatic test_clr();
        logic [NA-1:0] exp_v;
        do_reset();
        do_write(4'd0, 8'd5);    // row 1
        do_write(4'd1, 8'd12);   // row 2
        do_set();
        exp_v = '0;
        exp_v[5] = 1'b1;
        checks++;
        if (axon_spikes !== exp_v) begin
            errors++;
            $display("FAIL clr_pre: got %h expected %h", axon_spikes, exp_v);
        end
        do_clr();
        exp_v = '0;
        checks++;
        if (axon_spikes !== exp_v || rd_ptr !== 4'd1) begin
            errors++;
            $display("FAIL clr_post: got ptr=%0d spikes=%h expected ptr=1 spikes=%h",
                     rd_ptr, axon_spikes, exp_v);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL clr_error: got %b expected 0", error);
        end
        do_set();
        exp_v[12] = 1'b1;
        checks++;
        if (axon_spikes !== exp_v || rd_ptr !== 4'd2) begin
            errors++;
            $display("FAIL clr_next_row: got ptr=%0d spikes=%h expected ptr=2 spikes=%h",
                     rd_ptr, axon_spikes, exp_v);
        end
        // set+clr together at rd_ptr=2: row 2 cleared, pointer advances, error raised
        cycle(1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (rd_ptr !== 4'd3 || error !== 1'b1) begin
            errors++;
            $display("FAIL setclr: got ptr=%0d err=%b expected ptr=3 err=1", rd_ptr, error);
        end
        for (int i = 0; i < NT - 1; i++) do_set();
        exp_v = '0;
        checks++;
        if (rd_ptr !== 4'd2 || axon_spikes !== exp_v) begin
            errors++;
            $display("FAIL setclr_row2: got ptr=%0d spikes=%h expected ptr=2 spikes=%h",
                     rd_ptr, axon_spikes, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [NA-1:0] exp_v;
        do_reset();
        for (int i = 0; i < 4; i++) do_set();
        cycle(1'b1, 4'd0, 8'd3, 1'b1, 1'b0, 1'b0);   // write uses old rd_ptr=4 -> row 5
        exp_v = '0;
        exp_v[3] = 1'b1;
        checks++;
        if (rd_ptr !== 4'd5) begin
            errors++;
            $display("FAIL b2b_rd_ptr: got %0d expected 5", rd_ptr);
        end
        checks++;
        if (axon_spikes !== exp_v) begin
            errors++;
            $display("FAIL b2b_old_ptr_write: got %h expected %h", axon_spikes, exp_v);
        end
        do_write(4'd0, 8'd0);
        do_write(4'd0, 8'd255);
        do_write(4'd0, 8'd0);     // duplicate is idempotent
        do_write(4'd3, 8'd100);   // row 9
        do_set();
        exp_v = '0;
        exp_v[0]   = 1'b1;
        exp_v[255] = 1'b1;
        checks++;
        if (axon_spikes !== exp_v || rd_ptr !== 4'd6) begin
            errors++;
            $display("FAIL b2b_multi: got ptr=%0d spikes=%h expected ptr=6 spikes=%h",
                     rd_ptr, axon_spikes, exp_v);
        end
        // reset mid-tick with a packet in flight: everything pending is discarded
        cycle(1'b1, 4'd1, 8'd42, 1'b1, 1'b0, 1'b1);
        exp_v = '0;
        checks++;
        if (rd_ptr !== 4'd0 || axon_spikes !== exp_v || error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rst: got ptr=%0d spikes=%h err=%b expected ptr=0 spikes=0 err=0",
                     rd_ptr, axon_spikes, error);
        end
        for (int i = 1; i < NT; i++) begin
            do_set();
            checks++;
            if (axon_spikes !== exp_v) begin
                errors++;
                $display("FAIL b2b_rst_row%0d: got %h expected %h", i, axon_spikes, exp_v);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_delay  = '0;
        wr_axon   = '0;
        sched_set = 1'b0;
        sched_clr = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_delay();
        test_wrap();
        test_alias();
        test_clr();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
